// File: rtl/meas_link_pkg.sv
// ---------------------------------------------------------------------------
// meas_link_pkg
// Shared definitions for the cymometer measurement-link receiver:
//   - rx_state_e   : receiver FSM states
//   - FRAME_BYTES  : bytes per measurement frame
//   - BYTE_BITS    : bits per serial byte
//   - LSB_FIRST    : byte order on the wire (byte 0 carries frame bits [7:0])
//   - calc_bps_cnt : clock cycles per bit period
// ---------------------------------------------------------------------------
package meas_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    localparam int FRAME_BYTES = 8;
    localparam int BYTE_BITS   = 8;
    localparam bit LSB_FIRST   = 1'b1;

    // Integer division: the fractional part of a bit period is dropped.
    function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/meas_frame_rx_if.sv
// ---------------------------------------------------------------------------
// meas_frame_rx_if
// Serial input and decoded outputs of the measurement-link receiver.
//   uart_rxd      : serial line, idle high (driven by the link side)
//   byte_data     : last correctly received byte
//   byte_valid    : one-cycle pulse, byte_data new
//   frame_data    : last complete 64-bit frame
//   cnt_fs/cnt_fx : upper/lower 32 bits of frame_data
//   frame_valid   : one-cycle pulse, frame_data new
//   frame_err     : one-cycle pulse, stop bit sampled low
//   frame_timeout : one-cycle pulse, partial frame dropped
// Modports: slave = receiver, master = line driver / consumer.
// ---------------------------------------------------------------------------
interface meas_frame_rx_if;

    logic        uart_rxd;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [63:0] frame_data;
    logic [31:0] cnt_fs;
    logic [31:0] cnt_fx;
    logic        frame_valid;
    logic        frame_err;
    logic        frame_timeout;

    modport slave (
        input  uart_rxd,
        output byte_data, byte_valid, frame_data, cnt_fs, cnt_fx,
               frame_valid, frame_err, frame_timeout
    );

    modport master (
        output uart_rxd,
        input  byte_data, byte_valid, frame_data, cnt_fs, cnt_fx,
               frame_valid, frame_err, frame_timeout
    );

endinterface

// File: rtl/uart_recv.sv
// ---------------------------------------------------------------------------
// uart_recv
// 8N1 UART byte receiver with input synchroniser and break handling.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_rxd          : asynchronous serial input, idle high
//   o_byte_data    : last good byte (updates with o_byte_valid)
//   o_byte_valid   : one-cycle pulse on a byte with a good stop bit
//   o_frame_err    : one-cycle pulse when the stop bit is sampled low
//   o_rx_fall      : falling edge seen on the synchronised line
//   o_idle         : FSM is in IDLE
// ---------------------------------------------------------------------------
module uart_recv
    import meas_link_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115_200
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rxd,
    output logic [7:0] o_byte_data,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_rx_fall,
    output logic       o_idle
);

    localparam int BPS_CNT  = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam int HALF_CNT = BPS_CNT / 2;
    localparam int BAUD_W   = $clog2(BPS_CNT);

    logic              r_sync1, r_sync2, r_sync3;
    logic              w_rx_s, w_fall;
    rx_state_e         r_state, w_state_nxt;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [3:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_byte_data;
    logic              r_byte_valid, r_frame_err;
    logic              w_tick, w_byte_valid_nxt, w_frame_err_nxt;

    // Two-flop synchroniser plus a history flop for falling-edge detect
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rx_s = r_sync2;
    assign w_fall = r_sync3 & ~r_sync2;

    // Sample tick: mid start bit in START, one full bit period in DATA/STOP
    always_comb begin
        w_tick = 1'b0;
        case (r_state)
            ST_START:         w_tick = (r_baud_cnt == BAUD_W'(HALF_CNT - 1));
            ST_DATA, ST_STOP: w_tick = (r_baud_cnt == BAUD_W'(BPS_CNT - 1));
            default:          w_tick = 1'b0;
        endcase
    end

    // Bit-period counter, restarted on every sample and parked while waiting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_baud_cnt <= {BAUD_W{1'b0}};
        end else if (w_tick || (r_state == ST_IDLE) || (r_state == ST_BREAK)) begin
            r_baud_cnt <= {BAUD_W{1'b0}};
        end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
        end
    end

    // Data bit counter (saturates at 8) and LSB-first shift register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
        end else if (r_state == ST_IDLE) begin
            r_bit_cnt <= 4'd0;
        end else if ((r_state == ST_DATA) && w_tick) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
            if (r_bit_cnt != 4'd8) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
        end else begin
            r_bit_cnt <= r_bit_cnt;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) w_state_nxt = ST_START;
                else        w_state_nxt = ST_IDLE;
            end
            ST_START: begin
                // A line that is high again at mid start bit was a glitch
                if (w_tick) w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                else        w_state_nxt = ST_START;
            end
            ST_DATA: begin
                if (w_tick && (r_bit_cnt == 4'd7)) w_state_nxt = ST_STOP;
                else                               w_state_nxt = ST_DATA;
            end
            ST_STOP: begin
                if (w_tick) w_state_nxt = w_rx_s ? ST_IDLE : ST_BREAK;
                else        w_state_nxt = ST_STOP;
            end
            ST_BREAK: begin
                // Hold off new start bits until the line returns high
                if (w_rx_s) w_state_nxt = ST_IDLE;
                else        w_state_nxt = ST_BREAK;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode: stop-bit outcome
    always_comb begin
        w_byte_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        if ((r_state == ST_STOP) && w_tick) begin
            w_byte_valid_nxt = w_rx_s;
            w_frame_err_nxt  = ~w_rx_s;
        end else begin
            w_byte_valid_nxt = 1'b0;
            w_frame_err_nxt  = 1'b0;
        end
    end

    // Registered byte outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_byte_data  <= 8'h00;
        end else begin
            r_byte_valid <= w_byte_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
            if (w_byte_valid_nxt) r_byte_data <= r_shift;
            else                  r_byte_data <= r_byte_data;
        end
    end

    assign o_byte_data  = r_byte_data;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;
    assign o_rx_fall    = w_fall;
    assign o_idle       = (r_state == ST_IDLE);

endmodule

// File: rtl/meas_frame_rx.sv
// ---------------------------------------------------------------------------
// meas_frame_rx
// Receiving end of the cymometer measurement link: UART bytes are assembled
// into 8-byte frames {cnt_fs, cnt_fx}; partial frames are dropped after
// TIMEOUT_BITS idle bit periods.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : uart_rxd in; byte/frame data, valid and error pulses out
// ---------------------------------------------------------------------------
module meas_frame_rx
    import meas_link_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int UART_BPS     = 115_200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    meas_frame_rx_if.slave bus
);

    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam int TO_CNT  = TIMEOUT_BITS * BPS_CNT;
    localparam int TO_W    = $clog2(TO_CNT + 1);
    localparam int IDX_W   = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);

    logic [7:0]       w_byte_data;
    logic             w_byte_valid, w_frame_err, w_rx_fall, w_rx_idle;
    logic [IDX_W-1:0] r_idx, w_slot;
    logic [63:0]      r_asm, w_asm_upd, r_frame_data;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_frame_valid, r_frame_timeout;
    logic             w_to_hit;

    uart_recv #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_recv (
        .i_clk        (sys_clk),
        .i_rst_n      (sys_rst_n),
        .i_rxd        (bus.uart_rxd),
        .o_byte_data  (w_byte_data),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err),
        .o_rx_fall    (w_rx_fall),
        .o_idle       (w_rx_idle)
    );

    // Byte slot in the assembly register for the current byte index
    always_comb begin
        w_slot = r_idx;
        if (LSB_FIRST) w_slot = r_idx;
        else           w_slot = IDX_LAST - r_idx;
    end

    // Assembly register with the incoming byte merged into its slot
    always_comb begin
        w_asm_upd = r_asm;
        w_asm_upd[{w_slot, 3'b000} +: BYTE_BITS] = w_byte_data;
    end

    // Timeout fires only with a partial frame pending and a quiet line
    assign w_to_hit = w_rx_idle && (r_idx != {IDX_W{1'b0}}) && !w_byte_valid &&
                      !w_rx_fall && !w_frame_err && (r_to_cnt == TO_W'(TO_CNT - 1));

    // Idle-time counter for partial-frame timeout
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if (w_frame_err || w_byte_valid || w_rx_fall || !w_rx_idle ||
                     (r_idx == {IDX_W{1'b0}}) || w_to_hit) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Frame assembler: byte index, assembly register and completed frame
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_idx        <= {IDX_W{1'b0}};
            r_asm        <= 64'h0;
            r_frame_data <= 64'h0;
        end else if (w_frame_err) begin
            // A framing error abandons the frame; it outranks the timeout
            r_idx <= {IDX_W{1'b0}};
        end else if (w_byte_valid) begin
            r_asm <= w_asm_upd;
            if (r_idx == IDX_LAST) begin
                r_frame_data <= w_asm_upd;
                r_idx        <= {IDX_W{1'b0}};
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end else if (w_to_hit) begin
            r_idx <= {IDX_W{1'b0}};
        end else begin
            r_idx <= r_idx;
        end
    end

    // Frame-level status pulses
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frame_valid   <= 1'b0;
            r_frame_timeout <= 1'b0;
        end else begin
            r_frame_valid   <= w_byte_valid && !w_frame_err && (r_idx == IDX_LAST);
            r_frame_timeout <= w_to_hit;
        end
    end

    assign bus.byte_data     = w_byte_data;
    assign bus.byte_valid    = w_byte_valid;
    assign bus.frame_err     = w_frame_err;
    assign bus.frame_data    = r_frame_data;
    assign bus.cnt_fs        = r_frame_data[63:32];
    assign bus.cnt_fx        = r_frame_data[31:0];
    assign bus.frame_valid   = r_frame_valid;
    assign bus.frame_timeout = r_frame_timeout;

endmodule

// File: tb/tb_meas_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_meas_frame_rx
// Self-checking bench for meas_frame_rx with a short bit period (20 clocks).
// ---------------------------------------------------------------------------
module tb_meas_frame_rx;

    localparam int CLK_FREQ     = 2_000_000;
    localparam int UART_BPS     = 100_000;
    localparam int TIMEOUT_BITS = 20;
    localparam int BPS          = 20;
    localparam int CLK_P        = 10;
    localparam int LAT          = 3 + BPS / 2 + 9 * BPS;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        logic [7:0] exp_byte;
        int         exp_bv;
        int         exp_err;
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    meas_frame_rx_if bus ();

    meas_frame_rx #(
        .CLK_FREQ     (CLK_FREQ),
        .UART_BPS     (UART_BPS),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Observed DUT events (written only by the monitor)
    logic [7:0]  obs_bytes[$];
    time         obs_t[$];
    logic [63:0] obs_frames[$];
    logic [31:0] obs_fs[$];
    logic [31:0] obs_fx[$];
    int          n_err = 0;
    int          n_to  = 0;

    // Expected results (written only by the main sequence)
    logic [7:0]  exp_bytes[$];
    logic [63:0] exp_frames[$];
    int          rd_b = 0;
    int          rd_f = 0;
    int          checks = 0;
    int          errors = 0;
    time         t_fall = 0;

    // Monitor: record output pulses on the falling clock edge
    always @(negedge sys_clk) begin
        if (bus.byte_valid) begin
            obs_bytes.push_back(bus.byte_data);
            obs_t.push_back($time);
        end
        if (bus.frame_valid) begin
            obs_frames.push_back(bus.frame_data);
            obs_fs.push_back(bus.cnt_fs);
            obs_fx.push_back(bus.cnt_fx);
        end
        if (bus.frame_err)     n_err <= n_err + 1;
        if (bus.frame_timeout) n_to  <= n_to + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok, input int stop_low_bits);
        bus.uart_rxd = 1'b0;
        t_fall = $time;
        idle(BPS);
        for (int b = 0; b < 8; b++) begin
            bus.uart_rxd = d[b];
            idle(BPS);
        end
        if (stop_ok) begin
            bus.uart_rxd = 1'b1;
            idle(BPS);
        end else begin
            bus.uart_rxd = 1'b0;
            idle(BPS * stop_low_bits);
            bus.uart_rxd = 1'b1;
            idle(BPS);
        end
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_bytes.push_back(d);
        send_byte(d, 1'b1, 0);
    endtask

    // Compare every expected byte/frame against the monitor, then check for extras
    task automatic check_sb(input string tag);
        logic [63:0] e;
        while (exp_bytes.size() != 0) begin
            e = 64'(exp_bytes.pop_front());
            if (rd_b < obs_bytes.size()) begin
                chk({tag, "_byte"}, 64'(obs_bytes[rd_b]), e);
                rd_b++;
            end else begin
                chk({tag, "_byte_missing"}, 64'(obs_bytes.size()), 64'(rd_b + 1));
            end
        end
        chk({tag, "_byte_extra"}, 64'(obs_bytes.size()), 64'(rd_b));
        rd_b = obs_bytes.size();
        while (exp_frames.size() != 0) begin
            e = exp_frames.pop_front();
            if (rd_f < obs_frames.size()) begin
                chk({tag, "_frame_data"}, obs_frames[rd_f], e);
                chk({tag, "_cnt_fs"}, 64'(obs_fs[rd_f]), 64'(e[63:32]));
                chk({tag, "_cnt_fx"}, 64'(obs_fx[rd_f]), 64'(e[31:0]));
                rd_f++;
            end else begin
                chk({tag, "_frame_missing"}, 64'(obs_frames.size()), 64'(rd_f + 1));
            end
        end
        chk({tag, "_frame_extra"}, 64'(obs_frames.size()), 64'(rd_f));
        rd_f = obs_frames.size();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_byte_data"}, 64'(bus.byte_data), 64'h0);
        chk({tag, "_frame_data"}, bus.frame_data, 64'h0);
        chk({tag, "_cnt"}, {bus.cnt_fs, bus.cnt_fx}, 64'h0);
        chk({tag, "_pulses"}, 64'({bus.byte_valid, bus.frame_valid, bus.frame_err, bus.frame_timeout}), 64'h0);
    endtask

    task automatic pulse_reset();
        sys_rst_n = 1'b0;
        idle(3);
        sys_rst_n = 1'b1;
        idle(2);
    endtask

    vec_t vecs[5];
    int   nb0, ne0, nf0, nt0;
    time  lat;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[3] = '{8'h81, 1'b1, 8'h81, 1, 0};
        vecs[4] = '{8'h55, 1'b0, 8'h00, 0, 1};

        bus.uart_rxd = 1'b1;
        sys_rst_n    = 1'b0;
        idle(3);
        chk_outputs_zero("reset");
        sys_rst_n = 1'b1;
        idle(5);

        // Single bytes from the vector table
        for (int i = 0; i < 5; i++) begin
            nb0 = obs_bytes.size();
            ne0 = n_err;
            nf0 = obs_frames.size();
            send_byte(vecs[i].data, vecs[i].stop_ok, 2);
            idle(2 * BPS);
            chk($sformatf("vec%0d_bv_count", i), 64'(obs_bytes.size() - nb0), 64'(vecs[i].exp_bv));
            chk($sformatf("vec%0d_err_count", i), 64'(n_err - ne0), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d_no_frame", i), 64'(obs_frames.size() - nf0), 64'h0);
            if (vecs[i].exp_bv == 1 && obs_bytes.size() > nb0) begin
                chk($sformatf("vec%0d_data", i), 64'(obs_bytes[nb0]), 64'(vecs[i].exp_byte));
                lat = (obs_t[nb0] - t_fall) / CLK_P;
                chk($sformatf("vec%0d_latency_in_range", i),
                    64'((lat >= LAT - 1) && (lat <= LAT + 1)), 64'h1);
            end
        end
        rd_b = obs_bytes.size();

        // Short low glitch on an idle line, then a good byte
        ne0 = n_err;
        bus.uart_rxd = 1'b0;
        idle(BPS / 4);
        bus.uart_rxd = 1'b1;
        idle(2 * BPS);
        chk("glitch_no_byte", 64'(obs_bytes.size()), 64'(rd_b));
        chk("glitch_no_err", 64'(n_err - ne0), 64'h0);
        send_good(8'h3C);
        idle(2 * BPS);
        check_sb("glitch");

        // Eight back-to-back bytes form one frame
        pulse_reset();
        for (int i = 1; i <= 8; i++) send_good(8'(i));
        exp_frames.push_back(64'h0807060504030201);
        idle(2 * BPS);
        check_sb("frame1");
        chk("frame1_hold", bus.frame_data, 64'h0807060504030201);

        // Framing error discards the partial frame
        pulse_reset();
        ne0 = n_err;
        send_good(8'h99);
        send_byte(8'h55, 1'b0, 2);
        for (int i = 1; i <= 8; i++) send_good(8'(8'h11 * i));
        exp_frames.push_back(64'h8877665544332211);
        idle(2 * BPS);
        chk("ferr_pulse", 64'(n_err - ne0), 64'h1);
        check_sb("ferr");

        // Timeout drops three buffered bytes
        nt0 = n_to;
        send_good(8'hAA);
        send_good(8'hBB);
        send_good(8'hCC);
        idle(25 * BPS);
        chk("to_pulse", 64'(n_to - nt0), 64'h1);
        chk("to_frame_hold", bus.frame_data, 64'h8877665544332211);
        for (int i = 0; i < 8; i++) send_good(8'(8'hF0 + i));
        exp_frames.push_back(64'hF7F6F5F4F3F2F1F0);
        idle(2 * BPS);
        check_sb("timeout");
        chk("to_single", 64'(n_to - nt0), 64'h1);

        // Reset in the middle of byte 4 of a frame
        send_good(8'h01);
        send_good(8'h02);
        send_good(8'h03);
        check_sb("prereset");
        bus.uart_rxd = 1'b0;
        idle(BPS);
        for (int b = 0; b < 3; b++) begin
            bus.uart_rxd = b[0];
            idle(BPS);
        end
        sys_rst_n    = 1'b0;
        bus.uart_rxd = 1'b1;
        idle(2);
        chk_outputs_zero("midreset");
        sys_rst_n = 1'b1;
        idle(2 * BPS);
        for (int i = 0; i < 8; i++) send_good(8'(8'hA0 + i));
        exp_frames.push_back(64'hA7A6A5A4A3A2A1A0);
        idle(2 * BPS);
        check_sb("postreset");
        chk("end_err_total", 64'(n_err), 64'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/meas_frame_rx.md
Name: meas_frame_rx

Overview:
UART receiver and frame assembler; the receiving end of the cymometer measurement link. It deserialises 8N1 bytes from the 64-bit measurement channel and reassembles each 8-byte frame into {cnt_fs, cnt_fx}. It is used on the host-side or monitor FPGA, and in loopback against the cymometer top. Byte order on the wire is least-significant byte first: byte 0 carries frame bits [7:0].

Parameters:
CLK_FREQ, 50000000, sys_clk frequency in Hz
UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (434 at default), integer division
FRAME_BYTES, 8, bytes per frame; fixed at 8 in this revision
TIMEOUT_BITS, 20, idle bit-periods after which a partial frame is discarded

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset
uart_rxd  in  1  asynchronous serial input, idle high
byte_data  out  8  last correctly received byte
byte_valid  out  1  one-cycle pulse, byte_data new
frame_data  out  64  last complete frame
cnt_fs  out  32  frame_data[63:32]
cnt_fx  out  32  frame_data[31:0]
frame_valid  out  1  one-cycle pulse, frame_data new
frame_err  out  1  one-cycle pulse, stop bit sampled low
frame_timeout  out  1  one-cycle pulse, partial frame dropped

Behaviour:
- Reset: sys_rst_n, asynchronous, active-low; clock sys_clk. All outputs and state reset to 0; FSM to IDLE; byte index to 0. Synchroniser flops reset to 1 (line idle).
- uart_rxd passes through 2 flops to give rx_s; a third flop is used for falling-edge detect. No logic is fed directly from uart_rxd.
- FSM states:
  - IDLE: on a falling edge of rx_s -> START, bit counter cleared.
  - START: after BPS_CNT/2 cycles, sample rx_s. If 1 (glitch), return to IDLE with no output. If 0, go to DATA.
  - DATA: sample every BPS_CNT cycles, 8 samples, LSB first into a shift register, then go to STOP.
  - STOP: sample after BPS_CNT cycles.
    - Stop bit 1: byte_data updates and byte_valid pulses in the same cycle; go to IDLE.
    - Stop bit 0: frame_err pulses, the byte is discarded, the byte index is cleared, and the FSM goes to BREAK.
  - BREAK: wait for rx_s == 1, then go to IDLE. This prevents false starts during a break condition.
- Latency: byte_valid asserts 3 + BPS_CNT/2 + 9*BPS_CNT cycles (±1) after the uart_rxd falling edge.
- Assembler:
  - On byte_valid, byte index k (0..7) writes assembly register bits [8k+7:8k], and k increments.
  - When k == 7 is written, on the next cycle frame_data, cnt_fs and cnt_fx update, frame_valid pulses, and k returns to 0.
  - frame_data holds its value until the next complete frame.
- Timeout:
  - An idle counter runs while the FSM is IDLE and k != 0. It clears on any falling edge or byte_valid.
  - At TIMEOUT_BITS*BPS_CNT cycles: k returns to 0, frame_timeout pulses, and frame_data is unchanged.
  - With k == 0 the counter holds at 0 and no timeout pulse is generated.
- Simultaneous events: the frame_err clear of k has priority over timeout. The timeout counter is 0 whenever frame_err fires.
- Counter widths are clog2 of the maximum count. The bit counter saturates at 8. There is no wrap in DATA.
- Reset mid-byte or mid-frame: everything is aborted. The first falling edge after reset release starts a fresh byte at index 0.

Decomposition:
- Package meas_link_pkg:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK)
  - FRAME_BYTES
  - BPS_CNT computation function
  - byte-order constant (LSB first)
- Sub-module uart_recv: synchroniser, FSM, byte_data/byte_valid/frame_err.
- The top level holds the assembler, the timeout counter and the output registers.

Test Plan:
- Single byte 0xA5 at 115200 baud, correct stop bit -> one byte_valid with byte_data=0xA5; no frame_valid; frame_err=0.
- Bytes 0x01..0x08, back to back -> 8 byte_valid pulses, then one frame_valid with frame_data=0x0807060504030201, cnt_fs=0x08070605, cnt_fx=0x04030201.
- 100-cycle low glitch on an idle line -> no byte_valid and no frame_err; a following valid byte 0x3C is received correctly.
- Byte 0x55 with the stop bit held low for 2 bit times, then 8 good bytes 0x11..0x88 -> frame_err pulse, then frame_valid with frame_data=0x8877665544332211.
- 3 bytes, then idle for 25 bit times, then 8 bytes 0xF0..0xF7 -> frame_timeout pulse; exactly one frame_valid with frame_data=0xF7F6F5F4F3F2F1F0.
- sys_rst_n asserted during byte 4 of a frame, then a full frame sent -> outputs are 0 during reset; afterwards a single frame_valid with the new frame, and no stale bytes.
